// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store,
// using round-robin on conflict and a sticky watchdog that flags hung memory.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_resp,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_byte_enable,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_resp,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_byte_enable,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp,
    output logic                timeout_err
);
    localparam int WW = $clog2(TIMEOUT + 2);
    localparam logic [WW-1:0] TO = WW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t        state;
    logic          last_d;
    logic [WW-1:0] wdog;
    logic          d_req;
    logic          pick_d;

    assign d_req   = d_read | d_write;
    // On conflict, serve the side that did not win the previous grant
    assign pick_d  = d_req & (~i_read | ~last_d);
    assign i_resp  = (state == GNT_I) & mem_resp;
    assign d_resp  = (state == GNT_D) & mem_resp;
    assign i_rdata = i_resp ? mem_rdata : '0;
    assign d_rdata = d_resp ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            last_d          <= 1'b1;
            wdog            <= '0;
            timeout_err     <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
        end else begin
            if (state == IDLE) begin
                if (i_read | d_req) begin
                    state           <= pick_d ? GNT_D : GNT_I;
                    last_d          <= pick_d;
                    wdog            <= '0;
                    mem_read        <= pick_d ? ~d_write : 1'b1;
                    mem_write       <= pick_d & d_write;
                    mem_address     <= pick_d ? d_addr : i_addr;
                    mem_wdata       <= pick_d ? d_wdata : '0;
                    mem_byte_enable <= pick_d ? d_byte_enable : '1;
                end
            end else if (mem_resp) begin
                state     <= IDLE;
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end else if (wdog != '1) begin
                wdog <= wdog + 1'b1;
            end
            if (TIMEOUT != 0 && state != IDLE && wdog == TO)
                timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven cycle vectors plus directed sequences for
// watchdog, reset mid-transaction and reset-time contention.
module tb_mem_port_arbiter;
    logic        clk = 0;
    logic        rst;
    logic        i_read, d_read, d_write, mem_resp;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_byte_enable;
    logic [31:0] i_rdata, d_rdata, mem_address, mem_wdata;
    logic        i_resp, d_resp, mem_read, mem_write, timeout_err;
    logic [3:0]  mem_byte_enable;
    logic [31:0] z_i_rdata, z_d_rdata, z_mem_address, z_mem_wdata;
    logic        z_i_resp, z_d_resp, z_mem_read, z_mem_write, z_timeout_err;
    logic [3:0]  z_mem_byte_enable;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_resp(i_resp), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_byte_enable(d_byte_enable), .d_rdata(d_rdata),
        .d_resp(d_resp), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .timeout_err(timeout_err)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut_nowd (
        .clk(clk), .rst(rst), .i_read(i_read), .i_addr(i_addr), .i_rdata(z_i_rdata),
        .i_resp(z_i_resp), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_byte_enable(d_byte_enable), .d_rdata(z_d_rdata),
        .d_resp(z_d_resp), .mem_read(z_mem_read), .mem_write(z_mem_write),
        .mem_address(z_mem_address), .mem_wdata(z_mem_wdata),
        .mem_byte_enable(z_mem_byte_enable), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .timeout_err(z_timeout_err)
    );

    typedef struct {
        logic ir; logic [31:0] ia;
        logic dr; logic dw; logic [31:0] da; logic [31:0] dwd; logic [3:0] dbe;
        logic mr; logic [31:0] mrd;
        logic e_mr; logic e_mw; logic [31:0] e_ma; logic [31:0] e_mwd; logic [3:0] e_be;
        logic e_ir; logic [31:0] e_ird; logic e_dr; logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                                logic [31:0] da, logic [31:0] dwd, logic [3:0] dbe,
                                logic mr, logic [31:0] mrd, logic e_mr, logic e_mw,
                                logic [31:0] e_ma, logic [31:0] e_mwd, logic [3:0] e_be,
                                logic e_ir, logic [31:0] e_ird, logic e_dr,
                                logic [31:0] e_drd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.dbe = dbe;
        v.mr = mr; v.mrd = mrd; v.e_mr = e_mr; v.e_mw = e_mw; v.e_ma = e_ma;
        v.e_mwd = e_mwd; v.e_be = e_be; v.e_ir = e_ir; v.e_ird = e_ird;
        v.e_dr = e_dr; v.e_drd = e_drd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_read = 0; i_addr = 0; d_read = 0; d_write = 0; d_addr = 0;
        d_wdata = 0; d_byte_enable = 0; mem_resp = 0; mem_rdata = 0;
    endtask

    initial begin
        // ir ia     dr dw da     dwd          dbe  mr mrd   | mr mw ma     mwd          be   ir ird  dr drd
        vecs.push_back(mk(0, 0,    0, 0, 0,     0,           0,   0, 0,     0, 0, 0,     0,           0,   0, 0,    0, 0));
        vecs.push_back(mk(1, 'h60, 0, 0, 0,     0,           0,   0, 0,     0, 0, 0,     0,           0,   0, 0,    0, 0));
        vecs.push_back(mk(1, 'h60, 0, 0, 0,     0,           0,   0, 0,     1, 0, 'h60,  0,           'hF, 0, 0,    0, 0));
        vecs.push_back(mk(1, 'h60, 0, 0, 0,     0,           0,   0, 0,     1, 0, 'h60,  0,           'hF, 0, 0,    0, 0));
        vecs.push_back(mk(1, 'h60, 0, 0, 0,     0,           0,   0, 0,     1, 0, 'h60,  0,           'hF, 0, 0,    0, 0));
        vecs.push_back(mk(1, 'h60, 0, 0, 0,     0,           0,   1, 'h13,  1, 0, 'h60,  0,           'hF, 1, 'h13, 0, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0,     0,           0,   0, 0,     0, 0, 0,     0,           0,   0, 0,    0, 0));
        vecs.push_back(mk(0, 0,    0, 1, 'h100, 'hDEADBEEF,  'h3, 0, 0,     0, 0, 0,     0,           0,   0, 0,    0, 0));
        vecs.push_back(mk(0, 0,    0, 1, 'h100, 'hDEADBEEF,  'h3, 0, 0,     0, 1, 'h100, 'hDEADBEEF,  'h3, 0, 0,    0, 0));
        vecs.push_back(mk(0, 0,    0, 1, 'h200, 0,           'hF, 0, 0,     0, 1, 'h100, 'hDEADBEEF,  'h3, 0, 0,    0, 0));
        vecs.push_back(mk(0, 0,    0, 1, 'h200, 0,           'hF, 1, 'h55,  0, 1, 'h100, 'hDEADBEEF,  'h3, 0, 0,    1, 'h55));
        vecs.push_back(mk(0, 0,    0, 0, 0,     0,           0,   0, 0,     0, 0, 0,     0,           0,   0, 0,    0, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0,     0,           0,   1, 'h77,  0, 0, 0,     0,           0,   0, 0,    0, 0));
        vecs.push_back(mk(1, 'h40, 1, 0, 'h80,  0,           'hF, 0, 0,     0, 0, 0,     0,           0,   0, 0,    0, 0));
        vecs.push_back(mk(1, 'h40, 1, 0, 'h80,  0,           'hF, 0, 0,     1, 0, 'h40,  0,           'hF, 0, 0,    0, 0));
        vecs.push_back(mk(1, 'h40, 1, 0, 'h80,  0,           'hF, 1, 'h11,  1, 0, 'h40,  0,           'hF, 1, 'h11, 0, 0));
        vecs.push_back(mk(1, 'h40, 1, 0, 'h80,  0,           'hF, 0, 0,     0, 0, 0,     0,           0,   0, 0,    0, 0));
        vecs.push_back(mk(1, 'h40, 1, 0, 'h80,  0,           'hF, 0, 0,     1, 0, 'h80,  0,           'hF, 0, 0,    0, 0));
        vecs.push_back(mk(1, 'h40, 1, 0, 'h80,  0,           'hF, 1, 'h22,  1, 0, 'h80,  0,           'hF, 0, 0,    1, 'h22));
        vecs.push_back(mk(1, 'h40, 1, 0, 'h80,  0,           'hF, 0, 0,     0, 0, 0,     0,           0,   0, 0,    0, 0));
        vecs.push_back(mk(1, 'h40, 1, 0, 'h80,  0,           'hF, 1, 'h33,  1, 0, 'h40,  0,           'hF, 1, 'h33, 0, 0));
        vecs.push_back(mk(1, 'h40, 1, 0, 'h80,  0,           'hF, 0, 0,     0, 0, 0,     0,           0,   0, 0,    0, 0));
        vecs.push_back(mk(1, 'h40, 1, 0, 'h80,  0,           'hF, 1, 'h44,  1, 0, 'h80,  0,           'hF, 0, 0,    1, 'h44));
        vecs.push_back(mk(0, 0,    0, 0, 0,     0,           0,   0, 0,     0, 0, 0,     0,           0,   0, 0,    0, 0));
        vecs.push_back(mk(0, 0,    1, 1, 'h300, 'hA5A5A5A5,  'hC, 0, 0,     0, 0, 0,     0,           0,   0, 0,    0, 0));
        vecs.push_back(mk(0, 0,    1, 1, 'h300, 'hA5A5A5A5,  'hC, 0, 0,     0, 1, 'h300, 'hA5A5A5A5,  'hC, 0, 0,    0, 0));
        vecs.push_back(mk(0, 0,    1, 1, 'h300, 'hA5A5A5A5,  'hC, 1, 0,     0, 1, 'h300, 'hA5A5A5A5,  'hC, 0, 0,    1, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0,     0,           0,   0, 0,     0, 0, 0,     0,           0,   0, 0,    0, 0));

        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("reset mem_read", 32'(mem_read), 0);
        chk("reset mem_write", 32'(mem_write), 0);
        chk("reset mem_address", mem_address, 0);
        chk("reset mem_byte_enable", 32'(mem_byte_enable), 0);
        chk("reset timeout_err", 32'(timeout_err), 0);
        rst = 0;

        foreach (vecs[n]) begin
            @(negedge clk);
            i_read = vecs[n].ir; i_addr = vecs[n].ia; d_read = vecs[n].dr;
            d_write = vecs[n].dw; d_addr = vecs[n].da; d_wdata = vecs[n].dwd;
            d_byte_enable = vecs[n].dbe; mem_resp = vecs[n].mr; mem_rdata = vecs[n].mrd;
            #1;
            chk($sformatf("v%0d mem_read", n), 32'(mem_read), 32'(vecs[n].e_mr));
            chk($sformatf("v%0d mem_write", n), 32'(mem_write), 32'(vecs[n].e_mw));
            chk($sformatf("v%0d i_resp", n), 32'(i_resp), 32'(vecs[n].e_ir));
            chk($sformatf("v%0d i_rdata", n), i_rdata, vecs[n].e_ird);
            chk($sformatf("v%0d d_resp", n), 32'(d_resp), 32'(vecs[n].e_dr));
            chk($sformatf("v%0d d_rdata", n), d_rdata, vecs[n].e_drd);
            if (vecs[n].e_mr | vecs[n].e_mw) begin
                chk($sformatf("v%0d mem_address", n), mem_address, vecs[n].e_ma);
                chk($sformatf("v%0d mem_wdata", n), mem_wdata, vecs[n].e_mwd);
                chk($sformatf("v%0d mem_byte_enable", n), 32'(mem_byte_enable), 32'(vecs[n].e_be));
            end
        end

        // Watchdog: grant cycle k carries wdog=k-1, flag visible from grant cycle 6
        @(negedge clk); idle_inputs(); i_read = 1; i_addr = 'h500;
        @(negedge clk); #1;
        chk("wd granted", 32'(mem_read), 1);
        repeat (4) @(negedge clk);
        #1;
        chk("wd not yet", 32'(timeout_err), 0);
        @(negedge clk); #1;
        chk("wd set", 32'(timeout_err), 1);
        chk("wd disabled", 32'(z_timeout_err), 0);
        @(negedge clk); mem_resp = 1; mem_rdata = 'h99; #1;
        chk("wd late resp", i_rdata, 'h99);
        @(negedge clk); idle_inputs(); #1;
        chk("wd sticky", 32'(timeout_err), 1);
        chk("wd disabled after", 32'(z_timeout_err), 0);

        // Reset while GNT_D waits: transaction dropped, stray resp ignored
        @(negedge clk); d_write = 1; d_addr = 'h44; d_wdata = 'h1234; d_byte_enable = 'hF;
        @(negedge clk); #1;
        chk("rst pre mem_write", 32'(mem_write), 1);
        @(negedge clk); rst = 1; d_write = 0;
        @(negedge clk); rst = 0; mem_resp = 1; mem_rdata = 'h66; #1;
        chk("rst mem_write", 32'(mem_write), 0);
        chk("rst stray d_resp", 32'(d_resp), 0);
        chk("rst stray i_resp", 32'(i_resp), 0);
        chk("rst clears timeout", 32'(timeout_err), 0);

        // Both requesting straight out of reset: fetch wins first
        @(negedge clk); idle_inputs(); rst = 1;
        i_read = 1; i_addr = 'hA0; d_read = 1; d_addr = 'hB0; d_byte_enable = 'hF;
        @(negedge clk); rst = 0;
        @(negedge clk); #1;
        chk("rst both first", mem_address, 'hA0);
        mem_resp = 1;
        @(negedge clk); mem_resp = 0;
        @(negedge clk); #1;
        chk("rst both second", mem_address, 'hB0);
        chk("rst both second read", 32'(mem_read), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
